// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-master arbiter in front of a single-port, async-read RAM.
// Master 0 (CPU data port) wins ties from IDLE. An owner with a waiting rival is
// pre-empted after MAX_HOLD cycles unless it holds its lock. Handover between
// masters happens without an idle bubble.
// Optional build macro ARB_STALL_CNT_EN adds the m0_stall_cnt output, a saturating
// count of cycles in which master 0 requested without holding the grant.
module mem_port_arbiter #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 12,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    // master 0: CPU data port
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [DWIDTH-1:0] m0_wdata,
    input  logic [3:0]        m0_be,
    output logic              m0_gnt,
    output logic [DWIDTH-1:0] m0_rdata,
    // master 1: loader
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic              m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [DWIDTH-1:0] m1_wdata,
    input  logic [3:0]        m1_be,
    output logic              m1_gnt,
    output logic [DWIDTH-1:0] m1_rdata,
`ifdef ARB_STALL_CNT_EN
    output logic [15:0]       m0_stall_cnt,
`endif
    // RAM data port
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic [3:0]        mem_wbe,
    output logic              mem_wen,
    input  logic [DWIDTH-1:0] mem_rdata
);

    // One bit per owner so each grant output is a flop, not a decode.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;

    logic   own_req;
    logic   own_lock;
    logic   oth_req;
    state_e oth_state;

    // Present the current owner's and rival's controls in owner-relative terms.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        own_req   = 1'b0;
        own_lock  = 1'b0;
        oth_req   = 1'b0;
        oth_state = IDLE;
        case (state_q)
            OWN0: begin
                own_req   = m0_req;
                own_lock  = m0_lock;
                oth_req   = m1_req;
                oth_state = OWN1;
            end
            OWN1: begin
                own_req   = m1_req;
                own_lock  = m1_lock;
                oth_req   = m0_req;
                oth_state = OWN0;
            end
            default: ;
        endcase
    end

    // Next-state and hold-counter logic.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                hold_d = 8'd0;
                if (m0_req) begin
                    state_d = OWN0;
                end else if (m1_req) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!own_req) begin
                    // Owner finished: hand straight over if the rival is waiting.
                    state_d = oth_req ? oth_state : IDLE;
                    hold_d  = 8'd0;
                end else if (oth_req && !own_lock && hold_q >= HOLD_LAST) begin
                    // >= rather than == so an owner that ran past the limit while
                    // alone (or locked) is still pre-empted once the rival shows up.
                    state_d = oth_state;
                    hold_d  = 8'd0;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = 8'd0;
            end
        endcase
    end

    // State and hold counter registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            hold_q  <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign m0_gnt = state_q[0];
    assign m1_gnt = state_q[1];

    // Route the owner's beat to the RAM; drive zeros whenever no beat is live.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wbe   = 4'b0000;
        mem_wen   = 1'b0;
        if (state_q == OWN0 && m0_req) begin
            mem_addr  = m0_addr[AWIDTH+1:2];
            mem_wdata = m0_wdata;
            mem_wbe   = m0_be;
            mem_wen   = m0_we;
        end else if (state_q == OWN1 && m1_req) begin
            mem_addr  = m1_addr[AWIDTH+1:2];
            mem_wdata = m1_wdata;
            mem_wbe   = m1_be;
            mem_wen   = m1_we;
        end
    end

    // Read data is shared; only the owner's read beat gives it meaning.
    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;

    // Byte-lane and out-of-range address bits are ignored by a word-addressed RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[31:AWIDTH+2], m0_addr[1:0],
                                m1_addr[31:AWIDTH+2], m1_addr[1:0]};

`ifdef ARB_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Count master-0 waiting cycles, saturating at all-ones.
    always_comb begin
        stall_d = stall_q;
        if (m0_req && !m0_gnt && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign m0_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven vectors, directed corner sequences and
// randomized traffic checked against an ownership/tenure model of the arbiter.
// The ARB_STALL_CNT_EN checks are compiled in only when the macro is defined.
module tb_mem_port_arbiter;

    localparam int DW       = 32;
    localparam int AW       = 12;
    localparam int MAX_HOLD = 8;
    localparam int WORDS    = 1 << AW;

    logic clk = 1'b0;
    logic n_rst = 1'b0;

    logic [1:0]         req, lock, we;
    logic [1:0][31:0]   addr;
    logic [1:0][DW-1:0] wdata;
    logic [1:0][3:0]    be;

    logic          m0_gnt, m1_gnt;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wbe;
    logic          mem_wen;
    logic [DW-1:0] mem_rdata;
`ifdef ARB_STALL_CNT_EN
    logic [15:0]   m0_stall_cnt;
`endif

    // RAM written by the DUT's outputs, and the bench's own expectation of it.
    logic [DW-1:0] ram_phys  [WORDS];
    logic [DW-1:0] ram_model [WORDS];

    assign mem_rdata = ram_phys[mem_addr];

    always #5 clk = ~clk;

    mem_port_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .n_rst(n_rst),
        .m0_req(req[0]), .m0_lock(lock[0]), .m0_we(we[0]), .m0_addr(addr[0]),
        .m0_wdata(wdata[0]), .m0_be(be[0]), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
        .m1_req(req[1]), .m1_lock(lock[1]), .m1_we(we[1]), .m1_addr(addr[1]),
        .m1_wdata(wdata[1]), .m1_be(be[1]), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
`ifdef ARB_STALL_CNT_EN
        .m0_stall_cnt(m0_stall_cnt),
`endif
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wbe(mem_wbe),
        .mem_wen(mem_wen), .mem_rdata(mem_rdata)
    );

    int errors = 0;
    int checks = 0;

    // Model: who owns the port (-1 = nobody) and for how many cycles so far.
    int       m_owner = -1;
    int       m_ten   = 0;
    int       m_stall = 0;
    bit [1:0] beat_done = 2'b00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [3:0] b);
        logic [DW-1:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) r[8*k +: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    // Called just after a falling edge with inputs already driven: compare all outputs.
    task automatic settle();
        logic          beat;
        int            o;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [3:0]    eb;
        logic          ew;
        #1;
        check("m0_gnt", m0_gnt, m_owner == 0);
        check("m1_gnt", m1_gnt, m_owner == 1);
        beat = 1'b0;
        o    = 0;
        if (m_owner >= 0) begin
            o    = m_owner;
            beat = req[o];
        end
        ea = beat ? addr[o][AW+1:2] : '0;
        ed = beat ? wdata[o] : '0;
        eb = beat ? be[o] : 4'b0000;
        ew = beat ? we[o] : 1'b0;
        check("mem_addr", mem_addr, ea);
        check("mem_wdata", mem_wdata, ed);
        check("mem_wbe", mem_wbe, eb);
        check("mem_wen", mem_wen, ew);
        if (beat && !we[o]) begin
            check("rdata", (o == 0) ? m0_rdata : m1_rdata, ram_model[ea]);
        end
`ifdef ARB_STALL_CNT_EN
        check("stall_cnt", m0_stall_cnt, m_stall);
`endif
    endtask

    // Cross one rising edge: RAM takes the DUT's write, model applies the rules.
    task automatic advance();
        logic          cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic [3:0]    cb;
        int            o, x;
        cw = mem_wen; ca = mem_addr; cd = mem_wdata; cb = mem_wbe;
        @(posedge clk);
        if (n_rst) begin
            if (cw) ram_phys[ca] = merge(ram_phys[ca], cd, cb);
            beat_done = 2'b00;
            if (m_owner >= 0 && req[m_owner]) begin
                o = m_owner;
                beat_done[o] = 1'b1;
                if (we[o]) ram_model[addr[o][AW+1:2]] =
                    merge(ram_model[addr[o][AW+1:2]], wdata[o], be[o]);
            end
            if (req[0] && m_owner != 0 && m_stall < 65535) m_stall++;
            if (m_owner < 0) begin
                m_owner = req[0] ? 0 : (req[1] ? 1 : -1);
                m_ten   = 0;
            end else begin
                o = m_owner;
                x = 1 - o;
                if (!req[o]) begin
                    m_owner = req[x] ? x : -1;
                    m_ten   = 0;
                end else if (req[x] && !lock[o] && m_ten + 1 >= MAX_HOLD) begin
                    m_owner = x;
                    m_ten   = 0;
                end else begin
                    m_ten++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        req = 2'b00; lock = 2'b00; we = 2'b00;
        #1;
        check("rst_m0_gnt", m0_gnt, 1'b0);
        check("rst_m1_gnt", m1_gnt, 1'b0);
        check("rst_mem_wen", mem_wen, 1'b0);
        check("rst_mem_wbe", mem_wbe, 4'b0000);
        m_owner = -1; m_ten = 0; m_stall = 0; beat_done = 2'b00;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic new_payload(input int i);
        we[i]    = 1'($urandom_range(0, 1));
        lock[i]  = ($urandom_range(0, 3) == 0);
        addr[i]  = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 31)) << 2)
                   | 32'($urandom_range(0, 3));
        wdata[i] = $urandom;
        be[i]    = 4'($urandom_range(0, 15));
    endtask

    typedef struct packed {
        logic          r0, w0, r1, w1;
        logic          g0, g1, wen;
        logic [3:0]    wbe;
        logic [AW-1:0] a;
    } vec_t;

    vec_t vecs[$];

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [DW-1:0] orig;
        int            cnt0;
        bit            started, done;

        for (int i = 0; i < WORDS; i++) begin
            ram_phys[i]  = 32'h5A00_0000 ^ (i * 32'h0101_0107);
            ram_model[i] = ram_phys[i];
        end
        req = 2'b00; lock = 2'b00; we = 2'b00;
        addr = '0; wdata = '0; be = '0;
        @(negedge clk);
        do_reset();

        // ---- table-driven vectors: fixed payloads, one row per cycle ----
        addr[0] = 32'h10; wdata[0] = 32'hA5A5_0F0F; be[0] = 4'hF;
        addr[1] = 32'h20; wdata[1] = 32'h1234_5678; be[1] = 4'h3;
        //                 r0    w0    r1    w1    g0    g1    wen   wbe    a
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 12'd0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 12'd0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 12'd4});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 12'd0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 12'd8});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 12'd0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 12'd0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 12'd4});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 12'd0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 12'd8});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 12'd0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 12'd4});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 12'd0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 12'd0});
        for (int v = 0; v < vecs.size(); v++) begin
            req[0] = vecs[v].r0; we[0] = vecs[v].w0;
            req[1] = vecs[v].r1; we[1] = vecs[v].w1;
            settle();
            check($sformatf("vec%0d_g0", v), m0_gnt, vecs[v].g0);
            check($sformatf("vec%0d_g1", v), m1_gnt, vecs[v].g1);
            check($sformatf("vec%0d_wen", v), mem_wen, vecs[v].wen);
            check($sformatf("vec%0d_wbe", v), mem_wbe, vecs[v].wbe);
            check($sformatf("vec%0d_addr", v), mem_addr, vecs[v].a);
            advance();
        end

        // ---- reset in the middle of a write beat ----
        do_reset();
        orig = ram_model[16];
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'hDEAD_BEEF; be[0] = 4'hF;
        step();
        settle();
        check("midwr_wen_before", mem_wen, 1'b1);
        #2 n_rst = 1'b0;
        #1;
        check("midwr_m0_gnt", m0_gnt, 1'b0);
        check("midwr_m1_gnt", m1_gnt, 1'b0);
        check("midwr_wen", mem_wen, 1'b0);
        check("midwr_wbe", mem_wbe, 4'b0000);
        m_owner = -1; m_ten = 0; m_stall = 0; beat_done = 2'b00;
        @(posedge clk);
        #1 check("midwr_wen_in_rst", mem_wen, 1'b0);
        @(negedge clk);
        check("midwr_ram_untouched", ram_phys[16], orig);
        n_rst = 1'b1;
        settle();
        check("post_rst_no_early_gnt", m0_gnt, 1'b0);
        advance();
        settle();
        check("post_rst_gnt", m0_gnt, 1'b1);
        advance();
        req[0] = 1'b0; we[0] = 1'b0;
        step();

        // ---- m0 read alone at 0x10 ----
        do_reset();
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0000_0010; be[0] = 4'hF;
        settle();
        check("rd_gnt_latency0", m0_gnt, 1'b0);
        advance();
        settle();
        check("rd_gnt", m0_gnt, 1'b1);
        check("rd_addr", mem_addr, 12'd4);
        check("rd_data", m0_rdata, ram_model[4]);
        advance();
        req[0] = 1'b0;
        step();

        // ---- simultaneous requests: fixed priority then pre-emption, no bubble ----
        do_reset();
        req = 2'b11; we = 2'b00; lock = 2'b00;
        addr[0] = 32'h10; addr[1] = 32'h20;
        cnt0 = 0; started = 1'b0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            settle();
            if (started) check("prio_no_bubble", m0_gnt | m1_gnt, 1'b1);
            if (m0_gnt) begin
                started = 1'b1;
                cnt0++;
            end
            if (m1_gnt) done = 1'b1;
            advance();
        end
        check("prio_m1_reached", done, 1'b1);
        check("prio_m0_cycles", cnt0, MAX_HOLD);
        req = 2'b00;
        step();

        // ---- locked 20-beat loader burst while m0 waits ----
        do_reset();
        req[1] = 1'b1; lock[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF;
        addr[1] = 32'h100; wdata[1] = 32'hB000_0000;
        step();
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; be[0] = 4'hF;
        for (int b = 0; b < 20; b++) begin
            addr[1]  = 32'h100 + 32'(4 * b);
            wdata[1] = 32'hB000_0000 + 32'(b);
            settle();
            check($sformatf("burst%0d_m1_gnt", b), m1_gnt, 1'b1);
            advance();
        end
        req[1] = 1'b0; lock[1] = 1'b0;
        settle();
        check("burst_end_m1_gnt", m1_gnt, 1'b1);
        check("burst_end_wen", mem_wen, 1'b0);
        advance();
        settle();
        check("burst_m0_takes", m0_gnt, 1'b1);
        advance();
        check("burst_last_word", ram_phys[(32'h100 >> 2) + 19], 32'hB000_0013);
        req[0] = 1'b0;
        step();

        // ---- partial write by m1 while m0 waits with a read ----
        do_reset();
        orig = ram_model[8];
        req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'b0011; addr[1] = 32'h20; wdata[1] = 32'h1234_5678;
        step();
        req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h10;
        settle();
        check("pw_wbe", mem_wbe, 4'b0011);
        check("pw_wen", mem_wen, 1'b1);
        check("pw_addr", mem_addr, 12'd8);
        advance();
        req[1] = 1'b0; we[1] = 1'b0;
        settle();
        check("pw_wait_wen", mem_wen, 1'b0);
        advance();
        settle();
        check("pw_m0_no_write", mem_wen, 1'b0);
        advance();
        req[0] = 1'b0;
        step();
        check("pw_ram", ram_phys[8], {orig[31:16], 16'h5678});

        // ---- randomized traffic against the model ----
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (req[i] && beat_done[i]) begin
                    if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
                    else new_payload(i);
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    new_payload(i);
                end
            end
            step();
        end
        req = 2'b00; lock = 2'b00;
        step();

`ifdef ARB_STALL_CNT_EN
        // ---- stall counter: 5 blocked cycles, then saturation ----
        do_reset();
        req[1] = 1'b1; lock[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h20;
        step();
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
        repeat (5) step();
        #1 check("stall_5", m0_stall_cnt, 16'd5);
        for (int c = 0; c < 70000; c++) @(posedge clk);
        @(negedge clk);
        check("stall_sat", m0_stall_cnt, 16'hFFFF);
        req = 2'b00; lock = 2'b00;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
